cpu_fetch: RTL and testbench

Instruction fetch stage of the RV32 pipeline, directly upstream of the register-file read stage.
- Reads 32-bit instruction words from the instruction bus at the current PC.
- Extracts the rs1/rs2/rd fields and publishes them as fetch_data_t, using the codebase's tag handshake: a new tag value means new data.
- After any control-flow instruction, stalls until execute reports the resolved next PC.

---
 rtl/cpu_fetch_pkg.sv | 38 +++
 rtl/cpu_fetch.sv | 110 +++++++++++
 tb/tb_cpu_fetch.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/cpu_fetch_pkg.sv
// Shared CPU types: memory and fetch bundles, tag width, opcode constants.
// Imported by pipeline stages that exchange tagged instruction data.
package cpu_fetch_pkg;

    localparam int TAG_SIZE = 8;

    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef struct packed {
        logic [31:0] address;
        logic [31:0] data;
    } memory_data_t;

    typedef struct packed {
        logic [TAG_SIZE-1:0] tag;
        logic [31:0]         pc;
        logic [31:0]         instruction;
        logic [4:0]          inst_rs1;
        logic [4:0]          inst_rs2;
        logic [4:0]          inst_rd;
    } fetch_data_t;

    // True for any instruction whose successor PC is resolved by execute.
    function automatic logic is_control_flow(input logic [6:0] opcode);
        logic hit;
        hit = 1'b0;
        unique case (1'b1)
            (opcode == OP_JAL):    hit = 1'b1;
            (opcode == OP_JALR):   hit = 1'b1;
            (opcode == OP_BRANCH): hit = 1'b1;
            default:               hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/cpu_fetch.sv
// RV32 instruction fetch: one word at a time, tagged hand-off downstream.
// Ports: i_clock/i_reset (sync, active high); instruction bus
//   o_bus_request/o_bus_address/i_bus_ready/i_bus_rdata; i_pipeline_busy
//   back-pressure; i_execute_tag/i_execute_pc_next redirect; o_data bundle.
module cpu_fetch
    import cpu_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic                i_clock,
    input  logic                i_reset,
    output logic                o_bus_request,
    input  logic                i_bus_ready,
    output logic [31:0]         o_bus_address,
    input  logic [31:0]         i_bus_rdata,
    input  logic                i_pipeline_busy,
    input  logic [TAG_SIZE-1:0] i_execute_tag,
    input  logic [31:0]         i_execute_pc_next,
    output fetch_data_t         o_data
);

    typedef enum logic [1:0] {
        FETCH,
        ISSUE,
        WAIT_EXECUTE
    } state_t;

    localparam logic [31:0]         WORD_MASK = 32'hFFFF_FFFC;
    localparam logic [TAG_SIZE-1:0] TAG_ONE   = 1;

    state_t              state, state_n;
    logic [31:0]         pc, pc_n;
    logic [31:0]         buffer, buffer_n;
    logic [TAG_SIZE-1:0] wait_tag, wait_tag_n;
    logic [TAG_SIZE-1:0] tag_inc;
    fetch_data_t         data, data_n;
    logic                req, req_n;

    always_comb begin
        state_n    = state;
        pc_n       = pc;
        buffer_n   = buffer;
        wait_tag_n = wait_tag;
        data_n     = data;
        tag_inc    = data.tag + TAG_ONE;

        unique case (state)
            FETCH: begin
                // A ready without our own request is not a completion.
                if (req && i_bus_ready) begin
                    buffer_n = i_bus_rdata;
                    state_n  = ISSUE;
                end
            end
            ISSUE: begin
                if (!i_pipeline_busy) begin
                    data_n.tag         = tag_inc;
                    data_n.pc          = pc;
                    data_n.instruction = buffer;
                    data_n.inst_rs1    = buffer[19:15];
                    data_n.inst_rs2    = buffer[24:20];
                    data_n.inst_rd     = buffer[11:7];
                    if (is_control_flow(buffer[6:0])) begin
                        wait_tag_n = tag_inc;
                        state_n    = WAIT_EXECUTE;
                    end else begin
                        pc_n    = pc + 32'd4;
                        state_n = FETCH;
                    end
                end
            end
            WAIT_EXECUTE: begin
                if (i_execute_tag == wait_tag) begin
                    pc_n    = i_execute_pc_next & WORD_MASK;
                    state_n = FETCH;
                end
            end
            default: begin
                state_n = FETCH;
            end
        endcase

        // Request is registered: it rises on the edge entering FETCH and
        // stays up until the ready edge, keeping address stable meanwhile.
        req_n = (state_n == FETCH);
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state    <= FETCH;
            pc       <= RESET_VECTOR & WORD_MASK;
            buffer   <= '0;
            wait_tag <= '0;
            data     <= '0;
            req      <= 1'b0;
        end else begin
            state    <= state_n;
            pc       <= pc_n;
            buffer   <= buffer_n;
            wait_tag <= wait_tag_n;
            data     <= data_n;
            req      <= req_n;
        end
    end

    assign o_bus_request = req;
    assign o_bus_address = req ? (pc & WORD_MASK) : 32'h0;
    assign o_data        = data;

endmodule

// File: tb/tb_cpu_fetch.sv
// Directed bench for cpu_fetch: reset, issue, back-pressure, redirect,
// mid-transaction reset and tag wrap over a long straight-line run.
module tb_cpu_fetch;
    import cpu_fetch_pkg::*;

    logic                i_clock = 1'b0;
    logic                i_reset;
    logic                o_bus_request;
    logic                i_bus_ready;
    logic [31:0]         o_bus_address;
    logic [31:0]         i_bus_rdata;
    logic                i_pipeline_busy;
    logic [TAG_SIZE-1:0] i_execute_tag;
    logic [31:0]         i_execute_pc_next;
    fetch_data_t         o_data;

    int n_checks = 0;
    int n_errors = 0;

    always #5 i_clock = ~i_clock;

    cpu_fetch #(.RESET_VECTOR(32'h0000_1000)) dut (
        .i_clock           (i_clock),
        .i_reset           (i_reset),
        .o_bus_request     (o_bus_request),
        .i_bus_ready       (i_bus_ready),
        .o_bus_address     (o_bus_address),
        .i_bus_rdata       (i_bus_rdata),
        .i_pipeline_busy   (i_pipeline_busy),
        .i_execute_tag     (i_execute_tag),
        .i_execute_pc_next (i_execute_pc_next),
        .o_data            (o_data)
    );

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", name, got, exp);
        end
    endtask

    task automatic wait_req(input string name);
        int n;
        n = 0;
        while (o_bus_request !== 1'b1 && n < 20) begin
            @(negedge i_clock);
            n++;
        end
        chk({name, "_req"}, 32'(o_bus_request), 32'd1);
    endtask

    // Wait for the request, hold ready off for lat cycles, then complete.
    task automatic fetch_one(input string name, input logic [31:0] instr,
                             input logic [31:0] addr, input int lat);
        wait_req(name);
        chk({name, "_addr"}, o_bus_address, addr);
        for (int k = 0; k < lat; k++) begin
            @(negedge i_clock);
            chk({name, "_hold_req"}, 32'(o_bus_request), 32'd1);
            chk({name, "_hold_addr"}, o_bus_address, addr);
        end
        i_bus_ready = 1'b1;
        i_bus_rdata = instr;
        @(negedge i_clock);
        i_bus_ready = 1'b0;
        i_bus_rdata = $urandom;
        chk({name, "_req_drop"}, 32'(o_bus_request), 32'd0);
    endtask

    task automatic chk_issue(input string name, input int tag,
                             input logic [31:0] pc, input logic [31:0] instr,
                             input int rs1, input int rs2, input int rd);
        chk({name, "_tag"}, 32'(o_data.tag), 32'(tag));
        chk({name, "_pc"}, o_data.pc, pc);
        chk({name, "_instr"}, o_data.instruction, instr);
        chk({name, "_rs1"}, 32'(o_data.inst_rs1), 32'(rs1));
        chk({name, "_rs2"}, 32'(o_data.inst_rs2), 32'(rs2));
        chk({name, "_rd"}, 32'(o_data.inst_rd), 32'(rd));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        i_reset           = 1'b1;
        i_bus_ready       = 1'b0;
        i_bus_rdata       = 32'h0;
        i_pipeline_busy   = 1'b0;
        i_execute_tag     = '0;
        i_execute_pc_next = 32'h0;

        // Reset state
        repeat (2) @(negedge i_clock);
        chk("rst_req", 32'(o_bus_request), 32'd0);
        chk("rst_addr", o_bus_address, 32'h0);
        chk("rst_tag", 32'(o_data.tag), 32'd0);
        chk("rst_pc", o_data.pc, 32'h0);
        i_reset = 1'b0;
        chk("rst_rel_req", 32'(o_bus_request), 32'd0);

        // add a0, a0, a1 at the reset vector, 1-cycle bus latency
        fetch_one("t1", 32'h00B50533, 32'h0000_1000, 1);
        @(negedge i_clock);
        chk_issue("t1", 1, 32'h1000, 32'h00B50533, 10, 11, 10);

        // addi x0, x0, 0 next word
        fetch_one("t2", 32'h00000013, 32'h0000_1004, 0);
        @(negedge i_clock);
        chk_issue("t2", 2, 32'h1004, 32'h00000013, 0, 0, 0);

        // JAL under 5 cycles of back-pressure
        i_pipeline_busy = 1'b1;
        i_execute_tag   = 8'd2;
        fetch_one("t3", 32'h0080006F, 32'h0000_1008, 0);
        for (int k = 0; k < 5; k++) begin
            @(negedge i_clock);
            chk("t3_busy_tag", 32'(o_data.tag), 32'd2);
            chk("t3_busy_pc", o_data.pc, 32'h1004);
            chk("t3_busy_req", 32'(o_bus_request), 32'd0);
        end
        i_pipeline_busy = 1'b0;
        @(negedge i_clock);
        chk_issue("t3", 3, 32'h1008, 32'h0080006F, 0, 8, 0);

        // Waiting on execute; tag 2 must not release the stall
        i_execute_pc_next = 32'h0000_5550;
        for (int k = 0; k < 3; k++) begin
            @(negedge i_clock);
            chk("t4_wait_req", 32'(o_bus_request), 32'd0);
        end
        i_execute_tag     = 8'd3;
        i_execute_pc_next = 32'h0000_2002;
        @(negedge i_clock);
        i_execute_tag = 8'd0;
        chk("t4_redir_req", 32'(o_bus_request), 32'd1);
        chk("t4_redir_addr", o_bus_address, 32'h0000_2000);

        // beq x1, x2, 8 at the redirect target
        fetch_one("t5", 32'h00208463, 32'h0000_2000, 0);
        @(negedge i_clock);
        chk_issue("t5", 4, 32'h2000, 32'h00208463, 1, 2, 8);
        @(negedge i_clock);
        chk("t5_wait_req", 32'(o_bus_request), 32'd0);
        i_execute_tag     = 8'd4;
        i_execute_pc_next = 32'h0000_3000;
        @(negedge i_clock);

        // jalr x1, 0(x1)
        fetch_one("t6", 32'h000080E7, 32'h0000_3000, 0);
        @(negedge i_clock);
        chk_issue("t6", 5, 32'h3000, 32'h000080E7, 1, 0, 1);
        i_execute_tag     = 8'd5;
        i_execute_pc_next = 32'h0000_3007;
        @(negedge i_clock);
        chk("t6_redir_req", 32'(o_bus_request), 32'd1);
        chk("t6_redir_addr", o_bus_address, 32'h0000_3004);

        // Reset while the read at 0x3004 is outstanding
        @(negedge i_clock);
        i_reset = 1'b1;
        @(negedge i_clock);
        chk("t7_rst_req", 32'(o_bus_request), 32'd0);
        chk("t7_rst_tag", 32'(o_data.tag), 32'd0);
        chk("t7_rst_addr", o_bus_address, 32'h0);
        chk("t7_rst_instr", o_data.instruction, 32'h0);
        i_bus_ready = 1'b1;
        i_bus_rdata = 32'h0080006F;
        @(negedge i_clock);
        i_reset = 1'b0;
        @(negedge i_clock);
        i_bus_ready = 1'b0;
        chk("t7_stray_req", 32'(o_bus_request), 32'd1);
        chk("t7_stray_addr", o_bus_address, 32'h0000_1000);
        chk("t7_stray_tag", 32'(o_data.tag), 32'd0);
        fetch_one("t7", 32'h00000013, 32'h0000_1000, 0);
        @(negedge i_clock);
        chk_issue("t7", 1, 32'h1000, 32'h00000013, 0, 0, 0);

        // 300 straight-line instructions; tag wraps 255 -> 0
        for (int i = 0; i < 300; i++) begin
            logic [31:0] a;
            logic [31:0] ins;
            a   = 32'h0000_1004 + 32'(i) * 32'd4;
            ins = 32'h00000013 | (32'(i % 32) << 15);
            fetch_one("t8", ins, a, 0);
            @(negedge i_clock);
            chk("t8_tag", 32'(o_data.tag), 32'((i + 2) % 256));
            chk("t8_pc", o_data.pc, a);
            chk("t8_rs1", 32'(o_data.inst_rs1), 32'(i % 32));
        end
        chk("t8_next_addr", o_bus_address, 32'h0000_1004 + 32'd1200);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
